// File: rtl/fifo_wr_bulker.sv
// Write-domain burst aggregator feeding the async FIFO write port.
// Optional macro FIFO_WR_BULKER_AWFULL_GATE_EN holds burst start while fifo_awfull is high.
module fifo_wr_bulker #(
    parameter int DSIZE          = 8,
    parameter int BULK_NUMBER    = 10,
    parameter int WATCHDOG_LIMIT = 100
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DSIZE-1:0] s_data,
    input  logic             s_last,
    output logic             fifo_winc,
    output logic [DSIZE-1:0] fifo_wdata,
    input  logic             fifo_wfull,
    input  logic             fifo_awfull,
    output logic             busy,
    output logic [15:0]      bursts_sent
);
    localparam int IW = $clog2(BULK_NUMBER + 1);
    localparam int AW = (BULK_NUMBER > 1) ? $clog2(BULK_NUMBER) : 1;
    localparam int WW = $clog2(WATCHDOG_LIMIT + 1);
    localparam logic [IW-1:0] BULK_MAX  = IW'(BULK_NUMBER);
    localparam logic [WW-1:0] WD_EXPIRE = WW'(WATCHDOG_LIMIT - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [DSIZE-1:0]  bulk_buf [BULK_NUMBER];
    logic [IW-1:0]     wr_idx, rd_idx;
    logic [WW-1:0]     wd_cnt;
    logic              accept, wd_expire, trigger, start, last_write;

`ifdef FIFO_WR_BULKER_AWFULL_GATE_EN
    logic              trig_pend;
`else
    logic              unused_awfull;
    assign unused_awfull = fifo_awfull;
`endif

    assign busy = (state == DRAIN);

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        fifo_winc  = 1'b0;
        fifo_wdata = '0;
        accept     = 1'b0;
        wd_expire  = 1'b0;
        trigger    = 1'b0;
        start      = 1'b0;
        last_write = 1'b0;
        case (state)
            IDLE: begin
                s_ready   = (wr_idx < BULK_MAX);
                accept    = s_valid && s_ready;
                wd_expire = (wr_idx != '0) && !accept && (wd_cnt == WD_EXPIRE);
                trigger   = (accept && (s_last || (wr_idx == BULK_MAX - 1'b1))) || wd_expire;
`ifdef FIFO_WR_BULKER_AWFULL_GATE_EN
                // a trigger seen while almost-full stays pending in trig_pend
                start     = (trigger || trig_pend) && !fifo_awfull;
`else
                start     = trigger;
`endif
                if (start)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                fifo_winc  = (rd_idx < wr_idx) && !fifo_wfull;
                fifo_wdata = bulk_buf[rd_idx[AW-1:0]];
                last_write = fifo_winc && (rd_idx == wr_idx - 1'b1);
                if (last_write)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state       <= IDLE;
            wr_idx      <= '0;
            rd_idx      <= '0;
            wd_cnt      <= '0;
            bursts_sent <= '0;
        end else begin
            state <= state_nxt;
            if (last_write) begin
                wr_idx      <= '0;
                rd_idx      <= '0;
                bursts_sent <= bursts_sent + 1'b1;
            end else begin
                if (accept)
                    wr_idx <= wr_idx + 1'b1;
                if (fifo_winc)
                    rd_idx <= rd_idx + 1'b1;
            end
            // holds at the expiry value so a gated expiry keeps re-asserting
            if (state != IDLE || accept || wr_idx == '0)
                wd_cnt <= '0;
            else if (!wd_expire)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

`ifdef FIFO_WR_BULKER_AWFULL_GATE_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
            trig_pend <= 1'b0;
        else if (start)
            trig_pend <= 1'b0;
        else if (trigger)
            trig_pend <= 1'b1;
    end
`endif

    always_ff @(posedge wclk) begin
        if (accept)
            bulk_buf[wr_idx[AW-1:0]] <= s_data;
    end

endmodule

// File: tb/tb_fifo_wr_bulker.sv
// Bench for fifo_wr_bulker: directed scenarios plus random traffic against a word/burst model.
module tb_fifo_wr_bulker;
    localparam int BULK = 10;
    localparam int WD   = 100;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_data;
    logic        fifo_winc, fifo_wfull, fifo_awfull, busy;
    logic [7:0]  fifo_wdata;
    logic [15:0] bursts_sent;

    int n_assert = 0;
    int n_fail   = 0;

    // model: words accepted but not yet written, words in current group, idle count, bursts
    logic [7:0] exp_q[$];
    int         grp_cnt    = 0;
    int         idle_cnt   = 0;
    int         exp_bursts = 0;

    fifo_wr_bulker #(.DSIZE(8), .BULK_NUMBER(BULK), .WATCHDOG_LIMIT(WD)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata),
        .fifo_wfull(fifo_wfull), .fifo_awfull(fifo_awfull),
        .busy(busy), .bursts_sent(bursts_sent)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge wclk) begin
        if (wrst_n) begin
            if (fifo_winc) begin
                chk("no_write_into_full", {31'b0, fifo_wfull}, 32'd0);
                if (exp_q.size() == 0)
                    chk("spurious_write", {31'b0, fifo_winc}, 32'd0);
                else
                    chk("write_order", {24'b0, fifo_wdata}, {24'b0, exp_q.pop_front()});
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                grp_cnt++;
                idle_cnt = 0;
                if (s_last || grp_cnt == BULK) begin
                    exp_bursts++;
                    grp_cnt = 0;
                end
            end else if (grp_cnt > 0) begin
                idle_cnt++;
                if (idle_cnt == WD) begin
                    exp_bursts++;
                    grp_cnt  = 0;
                    idle_cnt = 0;
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge wclk);
        #1;
    endtask

    task automatic send_burst(input int n, input logic [7:0] first, input bit last);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = first + 8'(i);
            s_last  = last && (i == n - 1);
            @(negedge wclk);
            chk("ready_while_collecting", {31'b0, s_ready}, 32'd1);
            next_cyc();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge wclk);
            chk("idle_no_write", {31'b0, fifo_winc}, 32'd0);
            chk("idle_not_busy", {31'b0, busy}, 32'd0);
            next_cyc();
        end
    endtask

    task automatic expect_drain(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            @(negedge wclk);
            chk("drain_busy", {31'b0, busy}, 32'd1);
            chk("drain_not_ready", {31'b0, s_ready}, 32'd0);
            chk("drain_winc", {31'b0, fifo_winc}, 32'd1);
            chk("drain_wdata", {24'b0, fifo_wdata}, {24'b0, first + 8'(i)});
            next_cyc();
        end
        @(negedge wclk);
        chk("post_drain_idle", {31'b0, busy}, 32'd0);
        chk("post_drain_winc", {31'b0, fifo_winc}, 32'd0);
        chk("post_drain_ready", {31'b0, s_ready}, 32'd1);
        next_cyc();
    endtask

    initial begin
        int got;
        wrst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        fifo_wfull = 1'b0; fifo_awfull = 1'b0;
        #2;
        chk("rst_ready", {31'b0, s_ready}, 32'd1);
        chk("rst_winc", {31'b0, fifo_winc}, 32'd0);
        chk("rst_wdata", {24'b0, fifo_wdata}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_bursts", {16'b0, bursts_sent}, 32'd0);
        #20 wrst_n = 1'b1;
        next_cyc();

        // full burst
        send_burst(10, 8'h01, 1'b0);
        expect_drain(10, 8'h01);
        chk("full_burst_count", {16'b0, bursts_sent}, 32'd1);

        // s_last flush
        send_burst(3, 8'h11, 1'b1);
        expect_drain(3, 8'h11);
        chk("last_burst_count", {16'b0, bursts_sent}, 32'd2);

        // watchdog flush after WD idle cycles
        send_burst(2, 8'h21, 1'b0);
        idle_check(WD);
        expect_drain(2, 8'h21);
        chk("wd_burst_count", {16'b0, bursts_sent}, 32'd3);

        // accept on idle cycle WD-1 restarts the watchdog
        send_burst(2, 8'h31, 1'b0);
        idle_check(WD - 2);
        send_burst(1, 8'h33, 1'b0);
        idle_check(WD);
        expect_drain(3, 8'h31);
        chk("wd_restart_count", {16'b0, bursts_sent}, 32'd4);

        // full backpressure on drain cycles 3..7
        send_burst(10, 8'h51, 1'b0);
        got = 0;
        for (int d = 0; d < 30 && got < 10; d++) begin
            fifo_wfull = (d >= 2 && d <= 6);
            @(negedge wclk);
            chk("bp_winc", {31'b0, fifo_winc}, {31'b0, !fifo_wfull});
            if (fifo_winc) begin
                chk("bp_wdata", {24'b0, fifo_wdata}, {24'b0, 8'h51 + 8'(got)});
                got++;
            end
            next_cyc();
        end
        fifo_wfull = 1'b0;
        chk("bp_words", got, 32'd10);
        @(negedge wclk);
        chk("bp_idle", {31'b0, busy}, 32'd0);
        next_cyc();
        chk("bp_count", {16'b0, bursts_sent}, 32'd5);

        // almost-full gate
        fifo_awfull = 1'b1;
        send_burst(10, 8'h41, 1'b0);
`ifdef FIFO_WR_BULKER_AWFULL_GATE_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge wclk);
            chk("gate_not_ready", {31'b0, s_ready}, 32'd0);
            chk("gate_not_busy", {31'b0, busy}, 32'd0);
            chk("gate_no_write", {31'b0, fifo_winc}, 32'd0);
            next_cyc();
        end
        fifo_awfull = 1'b0;
        @(negedge wclk);
        chk("gate_release_idle", {31'b0, busy}, 32'd0);
        next_cyc();
        expect_drain(10, 8'h41);
`else
        expect_drain(10, 8'h41);
        fifo_awfull = 1'b0;
`endif
        chk("gate_count", {16'b0, bursts_sent}, 32'd6);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            s_valid    = ($urandom_range(99) < 70);
            s_last     = ($urandom_range(99) < 10);
            s_data     = 8'($urandom);
            fifo_wfull = ($urandom_range(99) < 25);
            next_cyc();
        end
        s_valid = 1'b0; s_last = 1'b0; fifo_wfull = 1'b0;
        repeat (WD + 40) next_cyc();
        chk("rand_bursts", {16'b0, bursts_sent}, {16'b0, 16'(exp_bursts)});
        chk("rand_all_written", exp_q.size(), 32'd0);

        // reset mid-drain
        send_burst(10, 8'h61, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge wclk);
            chk("pre_rst_winc", {31'b0, fifo_winc}, 32'd1);
            next_cyc();
        end
        wrst_n = 1'b0;
        #1;
        exp_q.delete();
        grp_cnt = 0; idle_cnt = 0; exp_bursts = 0;
        chk("midrst_winc", {31'b0, fifo_winc}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_wdata", {24'b0, fifo_wdata}, 32'd0);
        chk("midrst_bursts", {16'b0, bursts_sent}, 32'd0);
        next_cyc();
        wrst_n = 1'b1;
        @(negedge wclk);
        chk("postrst_ready", {31'b0, s_ready}, 32'd1);
        next_cyc();
        send_burst(3, 8'h71, 1'b1);
        expect_drain(3, 8'h71);
        chk("postrst_count", {16'b0, bursts_sent}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_bulker.md
# fifo_wr_bulker

Write-domain burst aggregator that sits directly upstream of the dual-clock async FIFO. It accepts a valid/ready word stream, collects up to BULK_NUMBER words in a local buffer, and then drains them back-to-back into the FIFO write port (winc/wdata), honouring the FIFO's full flag. A watchdog flushes a partial burst after WATCHDOG_LIMIT idle cycles, so trailing words are never stranded.

## Interface
- DSIZE, 8, data width; matches the FIFO DSIZE.
- BULK_NUMBER, 10, words per burst and local buffer depth; must be ≥ 2.
- WATCHDOG_LIMIT, 100, idle cycles with a non-empty buffer before a forced flush; must be ≥ 1.

Ports (clock and reset first):
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream ready.
- s_data  in  DSIZE  upstream word.
- s_last  in  1  end-of-message marker; qualified by the handshake.
- fifo_winc  out  1  FIFO write increment.
- fifo_wdata  out  DSIZE  FIFO write data.
- fifo_wfull  in  1  FIFO full flag.
- fifo_awfull  in  1  FIFO almost-full flag.
- busy  out  1  high while in DRAIN.
- bursts_sent  out  16  count of completed drains; wraps modulo 2^16.

## Operation
- **Accept.** An upstream word is accepted when s_valid && s_ready. It is written to buf[wr_idx], and wr_idx then increments.
- **State machine.** Two states, IDLE (collect) and DRAIN (emit).
  - In IDLE, s_ready = (wr_idx < BULK_NUMBER).
  - In DRAIN, s_ready = 0.
- **IDLE → DRAIN.** Taken on the next edge when any of the following holds:
  - an accept makes wr_idx == BULK_NUMBER;
  - an accept carries s_last = 1;
  - the watchdog expires.
  - Any combination of these in the same cycle causes a single transition.
- **Burst-start gate.** The transition is additionally gated as described under Configuration. While it is gated, the FSM stays in IDLE with s_ready = 0 if the buffer is full.
- **DRAIN.**
  - fifo_winc = (rd_idx < wr_idx) && !fifo_wfull.
  - fifo_wdata = buf[rd_idx].
  - rd_idx increments on each write.
- **DRAIN → IDLE.** Taken on the edge where the final word is written (rd_idx == wr_idx-1 && fifo_winc). On that edge:
  - wr_idx and rd_idx both clear to 0;
  - bursts_sent increments.
- **Watchdog.**
  - wd_cnt, $clog2(WATCHDOG_LIMIT+1) bits, increments in IDLE when wr_idx > 0 and there is no accept.
  - It clears on any accept, when wr_idx == 0, and in DRAIN.
  - It expires when wd_cnt == WATCHDOG_LIMIT-1 and there is no accept that cycle.
  - An accept in the expiry cycle cancels the expiry.
- **Empty buffer.** A DRAIN entry with an empty buffer is impossible, because every trigger requires wr_idx ≥ 1.

## Timing
- Reset values: s_ready = 1, fifo_winc = 0, fifo_wdata = 0, busy = 0, bursts_sent = 0. State is IDLE, and all indices and wd_cnt are 0. Buffer contents are don't-care.
- fifo_winc is combinational from state, the indices and fifo_wfull. It deasserts in the same cycle that fifo_wfull rises, so no write is ever issued into a full FIFO.
- Latency from the last accepted word to the first fifo_winc: 1 cycle (the transition edge), provided the FIFO is not full.
- Throughput in DRAIN: 1 word per cycle while fifo_wfull = 0. A full burst occupies BULK_NUMBER cycles in DRAIN plus 1 transition cycle.
- fifo_wfull toggling mid-burst stalls fifo_winc. Order and data are preserved, and there are no duplicates.
- wrst_n asserted mid-burst: all outputs return to their reset values asynchronously and the buffered words are discarded.

## Configuration
- FIFO_WR_BULKER_AWFULL_GATE_EN:
  - **Defined:** the IDLE→DRAIN transition additionally requires fifo_awfull = 0. A pending trigger is held until fifo_awfull falls, and the watchdog expiry stays latched while it waits.
  - **Undefined:** fifo_awfull is ignored and only fifo_wfull throttles writes.

## Test plan
- **Full burst.** Stream 10 words 0x01..0x0A with fifo_wfull = 0.
  - s_ready drops after the 10th accept.
  - fifo_winc is high for 10 consecutive cycles carrying 0x01..0x0A in order.
  - bursts_sent = 1, then s_ready = 1.
- **s_last flush.** Send 3 words, s_last on the 3rd → exactly 3 writes follow, then IDLE.
- **Watchdog.** Send 2 words then idle, with WATCHDOG_LIMIT = 100.
  - No write for 100 cycles after the last accept.
  - DRAIN is entered on the 100th idle cycle and exactly 2 writes follow.
  - A 3rd word arriving on cycle 99 restarts the count.
- **Full backpressure.** Hold fifo_wfull = 1 for cycles 3–7 of a 10-word drain → fifo_winc = 0 throughout; all 10 words are still delivered in order with no duplicates.
- **Almost-full gate.** Build with the macro and hold fifo_awfull = 1 while 10 words are collected → no DRAIN and s_ready = 0 until fifo_awfull falls; DRAIN starts 1 cycle later.
- **Reset mid-drain.** Assert wrst_n low after 4 of 10 writes → fifo_winc = 0 immediately, s_ready = 1 after release, bursts_sent = 0.
